// File: rtl/crc_stream_pkg.sv
// Shared types and default parameters for the serial CRC generator.
// The FSM state encoding lives here so the top and any future checker agree on it.
package crc_stream_pkg;

  localparam int          DEF_WIDTH = 8;
  localparam logic [31:0] DEF_POLY  = 32'h44;
  localparam logic [31:0] DEF_SEED  = 32'hD8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_EMIT  = 2'd2;

endpackage

// File: rtl/crc_lfsr_step.sv
// One serial update of the Galois-style CRC register: shift toward stage 0,
// XOR the feedback bit into every stage whose POLY tap is set.
module crc_lfsr_step
  import crc_stream_pkg::*;
#(
  parameter int               WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY)
) (
  input  logic [WIDTH-1:0] lfsr,
  input  logic             data_in,
  output logic [WIDTH-1:0] lfsr_next
);

  logic fb;

  // NOTE: every output of a combinational block gets a value on every path;
  // a missing assignment would silently infer a latch.
  always_comb begin
    fb        = lfsr[0] ^ data_in;
    lfsr_next = '0;
    for (int i = 0; i < WIDTH - 1; i++) begin
      lfsr_next[i] = lfsr[i+1] ^ (POLY[i] & fb);
    end
    lfsr_next[WIDTH-1] = fb;
  end

endmodule

// File: rtl/crc_stream_gen.sv
// Serial CRC generator: absorbs a bit stream, then emits the register LSB first
// under OUT_RDY flow control. Define CRC_STREAM_CHECK_EN to add a check-only mode.
module crc_stream_gen
  import crc_stream_pkg::*;
#(
  parameter int               WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
  input  logic CLK,
  input  logic RST,
  input  logic DATA_IN,
  input  logic DATA_VLD,
  input  logic FRAME_END,
  input  logic OUT_RDY,
  output logic CRC_OUT,
  output logic CRC_VLD,
  output logic BUSY,
  output logic DROP
`ifdef CRC_STREAM_CHECK_EN
  ,
  input  logic CHK_MODE,
  output logic CHK_DONE,
  output logic CRC_ERR
`endif
);

  localparam int            CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] absorbed;
  logic [CW-1:0]    cnt;
  logic             accepting;
  logic             chk_sel;

  crc_lfsr_step #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_step (
    .lfsr      (lfsr),
    .data_in   (DATA_IN),
    .lfsr_next (lfsr_next)
  );

  // A bit arriving together with FRAME_END is folded in before the frame closes.
  assign absorbed  = DATA_VLD ? lfsr_next : lfsr;
  assign accepting = (state == ST_IDLE) || (state == ST_SHIFT);

`ifdef CRC_STREAM_CHECK_EN
  assign chk_sel = CHK_MODE;
`else
  assign chk_sel = 1'b0;
`endif

  assign CRC_VLD = (state == ST_EMIT);
  assign CRC_OUT = CRC_VLD & lfsr[0];
  assign BUSY    = (state != ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
      lfsr  <= SEED;
      cnt   <= '0;
      DROP  <= 1'b0;
    end else begin
      DROP <= 1'b0;
      case (state)
        ST_IDLE, ST_SHIFT: begin
          lfsr <= absorbed;
          if (DATA_VLD) state <= ST_SHIFT;
          if (FRAME_END) begin
            if (chk_sel) begin
              lfsr  <= SEED;
              state <= ST_IDLE;
            end else begin
              state <= ST_EMIT;
              cnt   <= '0;
            end
          end
        end
        ST_EMIT: begin
          DROP <= DATA_VLD | FRAME_END;
          if (OUT_RDY) begin
            if (cnt == LAST_BIT) begin
              state <= ST_IDLE;
              lfsr  <= SEED;
              cnt   <= '0;
            end else begin
              lfsr <= lfsr >> 1;
              cnt  <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          lfsr  <= SEED;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef CRC_STREAM_CHECK_EN
  // A received frame that includes its own CRC leaves the register at zero.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      CHK_DONE <= 1'b0;
      CRC_ERR  <= 1'b0;
    end else begin
      CHK_DONE <= accepting & FRAME_END & CHK_MODE;
      CRC_ERR  <= accepting & FRAME_END & CHK_MODE & (absorbed != '0);
    end
  end
`endif

endmodule

// File: doc/crc_stream_gen.md
CRC_STREAM_GEN -- requirements
Module: crc_stream_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, CRC register width (2..32).
REQ-002 SHALL have parameter POLY, default 8'h44 (WIDTH bits), tap mask; bit i set means stage i XORs in feedback.
REQ-003 SHALL have parameter SEED, default 8'hD8 (WIDTH bits), register value at reset and at frame start.
REQ-004 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port DATA_IN  input  1  serial message bit.
REQ-007 SHALL have port DATA_VLD  input  1  DATA_IN is valid this cycle.
REQ-008 SHALL have port FRAME_END  input  1  pulse: message complete, start CRC output.
REQ-009 SHALL have port OUT_RDY  input  1  sink accepts CRC_OUT this cycle.
REQ-010 SHALL have port CRC_OUT  output  1  serial CRC bit, LSB (stage 0) first.
REQ-011 SHALL have port CRC_VLD  output  1  CRC_OUT is valid.
REQ-012 SHALL have port BUSY  output  1  high outside IDLE.
REQ-013 SHALL have port DROP  output  1  one-cycle pulse: input ignored during EMIT.

Function
REQ-014 SHALL implement a 3-state FSM: IDLE, SHIFT, EMIT.
REQ-015 Update step, fb = LFSR[0]^DATA_IN, SHALL be: LFSR[i] <= LFSR[i+1]^(POLY[i]&fb) for i<WIDTH-1, and LFSR[WIDTH-1] <= fb.
REQ-016 IDLE/SHIFT with DATA_VLD=1 SHALL apply one update step and enter/stay in SHIFT.
REQ-017 IDLE/SHIFT with FRAME_END=1 SHALL enter EMIT next cycle; if DATA_VLD is also high, the bit SHALL be absorbed first.
REQ-018 FRAME_END in IDLE with no prior data SHALL emit SEED unchanged.
REQ-019 In EMIT: CRC_VLD=1, CRC_OUT=LFSR[0]; on OUT_RDY=1 LFSR shifts right with zero fill and the bit counter increments.
REQ-020 OUT_RDY=0 in EMIT SHALL hold CRC_OUT, LFSR and counter stable; there is no timeout.
REQ-021 After the WIDTH-th accepted bit, the FSM SHALL return to IDLE and reload LFSR=SEED in the same edge.
REQ-022 Counter SHALL be $clog2(WIDTH+1) bits; it clears on EMIT entry and never wraps.
REQ-023 DATA_VLD or FRAME_END in EMIT SHALL be ignored and SHALL pulse DROP next cycle.
REQ-024 Outside EMIT: CRC_VLD=0, CRC_OUT=0.
REQ-025 Latency from FRAME_END to first CRC_VLD SHALL be 1 cycle; back-to-back frames SHALL be accepted in the cycle after the final bit is accepted.

Reset
REQ-026 RST=0 SHALL immediately force IDLE, LFSR=SEED, counter=0, CRC_OUT=0, CRC_VLD=0, BUSY=0, DROP=0 (CHK_DONE=0, CRC_ERR=0 when present).
REQ-027 Reset mid-SHIFT or mid-EMIT SHALL discard the frame with no partial output after release.

Configuration
REQ-028 With macro CRC_STREAM_CHECK_EN defined: add input CHK_MODE and outputs CHK_DONE and CRC_ERR.
REQ-029 With CHK_MODE=1 at FRAME_END: skip EMIT, pulse CHK_DONE for one cycle, set CRC_ERR=(LFSR!=0) in that cycle, reload SEED, and return to IDLE.
REQ-030 Without the macro, the ports SHALL be absent and the behaviour SHALL be generation only.

Structure
REQ-031 Package crc_stream_pkg SHALL hold the FSM state typedef and default WIDTH/POLY/SEED constants.
REQ-032 Combinational sub-module crc_lfsr_step SHALL compute the next LFSR value from (LFSR, DATA_IN) using POLY; the FSM and counter SHALL remain in crc_stream_gen.

Verification (WIDTH=8, POLY=8'h44, SEED=8'hD8)
REQ-033 FRAME_END only, OUT_RDY=1 -> CRC_OUT bits 0,0,0,1,1,0,1,1 over 8 cycles with CRC_VLD=1, then IDLE.
REQ-034 One bit DATA_IN=1 with FRAME_END in the same cycle -> LFSR=8'hA8; output 0,0,0,1,0,1,0,1.
REQ-035 Same as REQ-034 with OUT_RDY low for 3 cycles mid-stream -> bits held stable, sequence unchanged, 11 cycles of CRC_VLD.
REQ-036 DATA_VLD pulsed during EMIT -> DROP pulses once and the CRC sequence is unaffected.
REQ-037 RST low at the 4th emitted bit -> outputs 0 immediately; the next FRAME_END emits the SEED pattern.
REQ-038 (CRC_STREAM_CHECK_EN) Bits 1,0,0,0,1,0,1,0,1 then FRAME_END with CHK_MODE=1 -> CHK_DONE=1, CRC_ERR=0; flipping any bit -> CRC_ERR=1.
